// File: rtl/neuron_pkg.sv
// Shared definitions for the bit-serial neuron datapath: log2 helper and feeder state encoding.
package neuron_pkg;

    // Ceiling log2; log2(1) = 0. Identical helper to the one the core uses.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXT   = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/serial_sext_shifter.sv
// Loadable arithmetic right shifter; emits its word LSB-first, then the sign bit indefinitely.
module serial_sext_shifter #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic             q
);

    logic [width-1:0] sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= d;
        end else begin
            sh <= width'($signed(sh) >>> 1);
        end
    end

    assign q = sh[0];

endmodule

// File: rtl/serial_neuron_feeder.sv
// Frame skid buffer plus parallel-to-serial launcher feeding the bit-serial neuron core.
module serial_neuron_feeder
    import neuron_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned width     = 8,
    parameter int unsigned cnt_width = log2(width) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*width-1:0] in_data,
    input  logic [N*width-1:0] w_data,
    input  logic               abort,
    input  logic               core_rdy,
    output logic [N-1:0]       inp,
    output logic [N-1:0]       w,
    output logic               start,
    output logic               busy
);

    feeder_state_t        state, state_n;
    logic [cnt_width-1:0] cnt, cnt_n;
    logic                 buf_valid, buf_valid_n;
    logic [N*width-1:0]   buf_in, buf_w;
    logic                 start_n, busy_n;
    logic                 accept_c, launch_c, sh_load_c, sh_zero_c;

    assign in_ready = ~buf_valid;
    assign accept_c = in_valid & ~buf_valid & ~abort;

    // Buffer payload; only written on a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_in <= '0;
            buf_w  <= '0;
        end else if (accept_c) begin
            buf_in <= in_data;
            buf_w  <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            buf_valid <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            buf_valid <= buf_valid_n;
            start     <= start_n;
            busy      <= busy_n;
        end
    end

    // Next state; a handshake sets buf_valid after any launch clear so the new frame survives.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        buf_valid_n = buf_valid;
        start_n     = 1'b0;
        busy_n      = busy;
        launch_c    = 1'b0;
        sh_load_c   = 1'b0;
        sh_zero_c   = 1'b0;

        if (abort) begin
            state_n     = ST_IDLE;
            cnt_n       = '0;
            buf_valid_n = 1'b0;
            busy_n      = 1'b0;
            sh_load_c   = 1'b1;
            sh_zero_c   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (buf_valid) launch_c = 1'b1;
                end
                ST_SHIFT: begin
                    cnt_n = cnt + cnt_width'(1);
                    if (cnt == cnt_width'(width - 1)) state_n = ST_EXT;
                end
                ST_EXT: begin
                    if (core_rdy) begin
                        if (buf_valid) begin
                            launch_c = 1'b1;
                        end else begin
                            state_n   = ST_IDLE;
                            busy_n    = 1'b0;
                            sh_load_c = 1'b1;
                            sh_zero_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end
            endcase

            if (launch_c) begin
                state_n     = ST_SHIFT;
                cnt_n       = '0;
                buf_valid_n = 1'b0;
                start_n     = 1'b1;
                busy_n      = 1'b1;
                sh_load_c   = 1'b1;
            end
            if (accept_c) buf_valid_n = 1'b1;
        end
    end

    // Loading zeros parks the shifters so inp/w read 0 while idle.
    for (genvar i = 0; i < N; i++) begin : g_lane
        serial_sext_shifter #(.width(width)) u_inp_sh (
            .clk  (clk),
            .rst  (rst),
            .load (sh_load_c),
            .d    (sh_zero_c ? '0 : buf_in[i*width +: width]),
            .q    (inp[i])
        );
        serial_sext_shifter #(.width(width)) u_w_sh (
            .clk  (clk),
            .rst  (rst),
            .load (sh_load_c),
            .d    (sh_zero_c ? '0 : buf_w[i*width +: width]),
            .q    (w[i])
        );
    end

endmodule

// File: tb/tb_serial_neuron_feeder.sv
// Directed self-checking bench for serial_neuron_feeder with N=2, width=8.
module tb_serial_neuron_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] w_data;
    logic        abort;
    logic        core_rdy;
    logic [1:0]  inp;
    logic [1:0]  w;
    logic        start;
    logic        busy;

    int checks = 0;
    int errors = 0;

    serial_neuron_feeder #(.N(2), .width(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_data   (w_data),
        .abort    (abort),
        .core_rdy (core_rdy),
        .inp      (inp),
        .w        (w),
        .start    (start),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial bit k of each packed lane: the word bit k, or its sign bit once k passes bit 7.
    function automatic logic [1:0] sbit(input logic [15:0] pk, input int k);
        logic [1:0] r;
        int idx;
        idx = (k > 7) ? 7 : k;
        for (int i = 0; i < 2; i++) r[i] = pk[i*8 + idx];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bits(input string tag, input logic [15:0] id, input logic [15:0] wd,
                            input int k);
        chk({tag, "_inp"}, 32'(inp), 32'(sbit(id, k)));
        chk({tag, "_w"}, 32'(w), 32'(sbit(wd, k)));
        chk({tag, "_start"}, 32'(start), 32'(k == 0));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    localparam logic [15:0] A_IN = {8'hFA, 8'h05};
    localparam logic [15:0] A_W  = {8'h80, 8'h7F};
    localparam logic [15:0] B_IN = {8'h12, 8'hB4};
    localparam logic [15:0] B_W  = {8'hF0, 8'h0F};
    localparam logic [15:0] C_IN = {8'h99, 8'h66};
    localparam logic [15:0] C_W  = {8'h11, 8'hEE};
    localparam logic [15:0] D_IN = {8'h81, 8'h7E};
    localparam logic [15:0] D_W  = {8'h00, 8'hFF};
    localparam logic [15:0] E_IN = {8'hC3, 8'h3C};
    localparam logic [15:0] E_W  = {8'h55, 8'hAA};
    localparam logic [15:0] F_IN = {8'h01, 8'hFF};
    localparam logic [15:0] F_W  = {8'h7F, 8'h80};

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_data = A_IN; w_data = A_W;
        abort = 1'b0; core_rdy = 1'b0;
        #2;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_inp", 32'(inp), 32'd0);
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) tick;
        chk("rst_no_accept", 32'(in_ready), 32'd1);
        chk("rst_no_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick;

        // Frame A; core_rdy during SHIFT must be ignored, frame B buffered, C stalled.
        in_valid = 1'b1; in_data = A_IN; w_data = A_W;
        tick;
        chk("a_accept_ready", 32'(in_ready), 32'd0);
        chk("a_accept_nostart", 32'(start), 32'd0);
        in_valid = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            tick;
            chk_bits("a", A_IN, A_W, k);
            core_rdy = (k == 2);
            if (k == 4) begin
                in_valid = 1'b1; in_data = B_IN; w_data = B_W;
            end
            if (k == 5) begin
                chk("b_accepted", 32'(in_ready), 32'd0);
                in_data = C_IN; w_data = C_W;
            end
            if (k > 5) chk("c_stalled", 32'(in_ready), 32'd0);
        end
        core_rdy = 1'b1;
        tick;
        core_rdy = 1'b0;
        chk_bits("b", B_IN, B_W, 0);
        chk("b_launch_ready", 32'(in_ready), 32'd1);
        tick;
        chk_bits("b", B_IN, B_W, 1);
        chk("c_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            tick;
            chk_bits("b", B_IN, B_W, k);
        end

        // Abort in EXT with C buffered: everything clears, C never starts.
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_inp", 32'(inp), 32'd0);
        chk("abort_w", 32'(w), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("abort_nostart", 32'(start), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        // Frame D, then core_rdy in EXT with empty buffer alongside a handshake for E.
        in_valid = 1'b1; in_data = D_IN; w_data = D_W;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            tick;
            chk_bits("d", D_IN, D_W, k);
        end
        core_rdy = 1'b1; in_valid = 1'b1; in_data = E_IN; w_data = E_W;
        tick;
        core_rdy = 1'b0; in_valid = 1'b0;
        chk("gap_busy", 32'(busy), 32'd0);
        chk("gap_start", 32'(start), 32'd0);
        chk("gap_inp", 32'(inp), 32'd0);
        chk("gap_w", 32'(w), 32'd0);
        chk("gap_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k <= 4; k++) begin
            tick;
            chk_bits("e", E_IN, E_W, k);
        end
        chk("e_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-SHIFT.
        rst = 1'b0;
        #2;
        chk("mid_rst_inp", 32'(inp), 32'd0);
        chk("mid_rst_w", 32'(w), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start", 32'(start), 32'd0);
        tick;
        rst = 1'b1;
        tick;
        chk("post_rst_idle", 32'(busy), 32'd0);
        in_valid = 1'b1; in_data = F_IN; w_data = F_W;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick;
            chk_bits("f", F_IN, F_W, k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_neuron_feeder.md
Name: serial_neuron_feeder

Overview:
- Upstream stage of the bit-serial neuron core.
- Accepts one parallel frame (N input words and N weight words, each `width` bits, two's complement) through a valid/ready handshake.
- Converts the frame into N-lane LSB-first bit-serial streams for `inp` and `w`, with a one-cycle `start` aligned to bit 0.
- Holds one further frame in a skid buffer; launches it only after the core reports `rdy` for the frame in flight.

Parameters:
- N, 2, number of neuron inputs (serial lanes per stream)
- width, 8, bits per input/weight word
- cnt_width, log2(width)+1, bit-counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  frame offered
- in_ready  out  1  skid buffer empty; frame accepted when in_valid & in_ready at a rising edge
- in_data  in  N*width  input words; lane i = in_data[i*width +: width]
- w_data  in  N*width  weight words, same lane packing
- abort  in  1  synchronous clear of buffer and state machine
- core_rdy  in  1  rdy pulse from the neuron core
- inp  out  N  serial input bits to the core
- w  out  N  serial weight bits to the core
- start  out  1  one-cycle frame-start pulse to the core
- busy  out  1  high in SHIFT or EXT

Behaviour:
- Reset values (rst low, applied immediately): inp=0, w=0, start=0, busy=0, buffer empty (in_ready=1), state IDLE, bit counter 0.
- Skid buffer:
  - Registers {in_data, w_data} and sets buf_valid on handshake.
  - in_ready = ~buf_valid, combinational from the register only; no input-to-output paths.
- Per-lane shifters (2N):
  - On launch, load the lane word.
  - Each following cycle, arithmetic shift right (MSB replicated).
  - inp[i] / w[i] = shifter LSB.
  - The stream therefore continues with sign bits after bit width-1.
- State machine:
  - IDLE:
    - if buf_valid, launch at the next edge.
    - Launch = load shifters from buffer, clear buf_valid, start<=1, counter<=0, go to SHIFT.
  - SHIFT:
    - start high only in the first SHIFT cycle.
    - Counter increments each cycle.
    - When counter == width-1, go to EXT.
    - core_rdy is ignored in SHIFT.
  - EXT:
    - Sign extension continues indefinitely.
    - On core_rdy=1: if buf_valid, launch (next state SHIFT); else go to IDLE and inp/w are driven 0.
- Latency:
  - Frame accepted at edge E0 with machine IDLE → start=1 and bit 0 on inp/w after edge E1.
  - Back-to-back frames: core_rdy sampled at edge Ek → next start after Ek.
- Simultaneous events:
  - Handshake and launch at the same edge: the buffer load wins over the clear; buffer holds the new frame and buf_valid stays 1.
  - core_rdy together with a handshake in EXT while the buffer is empty: go to IDLE; the frame launches one edge later.
- abort:
  - Synchronous, takes priority over everything except rst.
  - Next edge: IDLE, buffer empty, outputs 0; a handshake in the same cycle is dropped.
- rst during SHIFT/EXT: the frame and the buffered frame are both discarded; the core must also be reset by its own reset.
- Arithmetic width: none beyond the counter. Words are passed unaltered; no saturation.

Decomposition:
- Shared package (neuron_pkg):
  - log2 function (same as the core's)
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_EXT=2'd2
- Sub-module serial_sext_shifter:
  - Parameter width.
  - Ports clk, rst, load, d[width-1:0], q (LSB out).
  - Instantiated 2N times in a generate loop.

Test Plan (N=2, width=8):
- Reset: hold rst=0 with in_valid=1 → in_ready=1, start=0, inp=2'b00, w=2'b00, busy=0; no frame accepted.
- Single frame: in_data={8'hFA,8'h05}, w_data={8'h80,8'h7F}, core_rdy=0 → one edge after acceptance start=1.
  - Bits 0..7 inp[0]=1,0,1,0,0,0,0,0 then 0s.
  - Bits 0..7 inp[1]=0,1,0,1,1,1,1,1 then 1s.
  - Bits 0..7 w[0]=1,1,1,1,1,1,1,0 then 0s.
  - Bits 0..7 w[1]=0,0,0,0,0,0,0,1 then 1s.
  - busy=1 throughout.
- Back-to-back: offer frame B during SHIFT of A → accepted, in_ready=0.
  - Frame C is stalled.
  - core_rdy pulse at cycle 12 → start for B on the next edge, in_ready=1 again.
- core_rdy during SHIFT (cycle 3) → ignored; EXT entered after bit 7 and held until a later core_rdy.
- core_rdy in EXT with buffer empty and a simultaneous handshake → IDLE for one cycle; start follows one edge later.
- abort in EXT with buffer full → next edge busy=0, in_ready=1, inp=w=0; no start issued.
- rst asserted mid-SHIFT (bit 4) → outputs 0 without waiting for a clock edge; after release, the first accepted frame starts cleanly at bit 0.
